spi_master_ram_if: RTL
======================

// Module: spi_master_ram_if
// PURPOSE
//  SPI initiator that drives the SPI-slave/single-port-RAM subsystem from a
//  parallel command interface. It serialises a 10-bit command word onto MOSI,
//  MSB first, framed by SS_n. For read-data commands (word[9:8]==2'b11) it then
//  captures 8 bits from MISO and returns them as rd_data.
//  It sits between the host/test controller and the SPI slave, on the same clk.
// PARAMETERS
//  LEAD_CYCLES  1  cycles SS_n is low before the first MOSI bit (>=1)
//  RD_WAIT      2  cycles between the last MOSI bit and the first MISO sample (>=0)
//  GAP_CYCLES   1  minimum cycles SS_n stays high after a frame (>=1)
// PORTS
//  clk       in   1   system clock; all logic on posedge
//  rst       in   1   asynchronous, active-high reset
//  start     in   1   request; accepted only when ready==1
//  cmd_word  in   10  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload
//  ready     out  1   high in IDLE; start is accepted this cycle
//  SS_n      out  1   slave select, active low
//  MOSI      out  1   serial data to slave, MSB first
//  MISO      in   1   serial data from slave, MSB first
//  rd_data   out  8   byte captured in the last read-data frame
//  rd_valid  out  1   one-cycle pulse: rd_data updated
//  done      out  1   one-cycle pulse: frame finished (any opcode)
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; SS_n=1, MOSI=0, ready=1, rd_data=0,
//   rd_valid=0, done=0, counters=0. Asserting rst mid-frame aborts immediately.
//   SS_n rises with rst. No done/rd_valid is issued for the aborted frame.
//  All outputs are registered. FSM: IDLE -> LEAD -> SHIFT_OUT -> [WAIT_RD -> SHIFT_IN] -> GAP -> IDLE.
//  IDLE: ready=1, SS_n=1, MOSI=0. Sampling start=1 (cycle T) latches cmd_word into a
//   10-bit shift register and the opcode into is_rd = (cmd_word[9:8]==2'b11).
//   It then goes to LEAD. start in any other state is ignored, with no queueing.
//  LEAD: T+1 .. T+LEAD_CYCLES. SS_n=0, MOSI=0, ready=0.
//  SHIFT_OUT: 10 cycles. MOSI = word[9], word[8], ... word[0], one bit per cycle.
//   The bit counter is 4 bits and ends at 9.
//   Exit: is_rd ? (RD_WAIT>0 ? WAIT_RD : SHIFT_IN) : GAP.
//  WAIT_RD: RD_WAIT cycles. SS_n=0, MOSI=0.
//  SHIFT_IN: 8 cycles. SS_n=0, MOSI=0. MISO is sampled on each posedge into
//   rx_shift = {rx_shift[6:0], MISO}. The first sample is the MSB.
//  GAP: the first GAP cycle has SS_n=1, MOSI=0, done=1, plus rd_valid=1 and
//   rd_data=rx_shift if is_rd. It stays GAP_CYCLES cycles, then returns to IDLE.
//  rd_data holds its value until the next read-data frame completes. Write and
//   rd-addr frames leave it unchanged.
//  Frame length (defaults), start at T: SS_n low T+1..T+11 (non-read), MOSI bits
//   T+2..T+11, done at T+12, ready again at T+13. Read-data: MISO sampled at the
//   ends of T+14..T+21, done and rd_valid at T+22, ready at T+23.
//  start held high continuously gives back-to-back frames separated by exactly
//   GAP_CYCLES plus the IDLE cycle.
//  cmd_word changes after acceptance have no effect on the frame in flight.
//  MISO is ignored outside SHIFT_IN.
// TESTING
//  1. Reset: rst=1 mid-SHIFT_OUT -> SS_n=1 and MOSI=0 the same cycle; no done;
//     after release, ready=1.
//  2. Write-addr: start, cmd_word=10'h0A5 -> SS_n low 11 cycles; MOSI serial
//     0010100101; done at T+12; rd_valid stays 0.
//  3. Read-data: cmd_word=10'h300, bench slave drives 8'hC3 on MISO in the
//     SHIFT_IN window -> rd_data=8'hC3 with rd_valid=done=1 at T+22.
//  4. Ignore-while-busy: second start with 10'h1FF during a frame -> frame
//     unchanged; no extra frame follows.
//  5. Back-to-back: start held high with 10'h000 then 10'h2FF -> two frames,
//     SS_n high for >=GAP_CYCLES between them.
//  6. End-to-end with the SPI slave and RAM: wr-addr 10'h010, wr-data 10'h15A,
//     rd-addr 10'h210, rd-data 10'h300 -> rd_data=8'h5A.

Source files
------------

// File: rtl/spi_master_ram_if.sv
// SPI initiator: serialises a 10-bit command MSB first under SS_n and, for
// read-data commands, captures one byte from MISO after a turnaround wait.
module spi_master_ram_if #(
   parameter int unsigned LEAD_CYCLES = 1,
   parameter int unsigned RD_WAIT     = 2,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] cmd_word,
   output logic       ready,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       done
);

   localparam int unsigned CMD_W   = 10;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned BIT_W   = 4;
   localparam int unsigned MAX_AB  = (LEAD_CYCLES > RD_WAIT) ? LEAD_CYCLES : RD_WAIT;
   localparam int unsigned MAX_CYC = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
   localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_SHIFT_OUT,
      ST_WAIT_RD,
      ST_SHIFT_IN,
      ST_GAP
   } state_e;

   state_e              state_q;
   logic [CMD_W-1:0]    tx_shift_q;
   logic [DATA_W-1:0]   rx_shift_q;
   logic [DATA_W-1:0]   rx_shift_d;
   logic [DATA_W-1:0]   rd_data_q;
   logic [BIT_W-1:0]    bit_cnt_q;
   logic [CW-1:0]       cyc_cnt_q;
   logic                is_rd_q;
   logic                ready_q;
   logic                ss_n_q;
   logic                mosi_q;
   logic                rd_valid_q;
   logic                done_q;

   // Next receive value including the bit on MISO at this edge.
   assign rx_shift_d = {rx_shift_q[DATA_W-2:0], MISO};

   // Outputs leave the FSM registers directly; each register holds the value
   // that belongs to the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rd_data_q  <= '0;
         bit_cnt_q  <= '0;
         cyc_cnt_q  <= '0;
         is_rd_q    <= 1'b0;
         ready_q    <= 1'b1;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  tx_shift_q <= cmd_word;
                  is_rd_q    <= (cmd_word[9:8] == 2'b11);
                  cyc_cnt_q  <= '0;
                  ready_q    <= 1'b0;
                  ss_n_q     <= 1'b0;
                  mosi_q     <= 1'b0;
                  state_q    <= ST_LEAD;
               end
            end
            ST_LEAD: begin
               if (cyc_cnt_q == CW'(LEAD_CYCLES - 1)) begin
                  mosi_q     <= tx_shift_q[CMD_W-1];
                  tx_shift_q <= {tx_shift_q[CMD_W-2:0], 1'b0};
                  bit_cnt_q  <= '0;
                  state_q    <= ST_SHIFT_OUT;
               end else begin
                  cyc_cnt_q <= cyc_cnt_q + CW'(1);
               end
            end
            ST_SHIFT_OUT: begin
               if (bit_cnt_q == BIT_W'(CMD_W - 1)) begin
                  mosi_q    <= 1'b0;
                  cyc_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  if (!is_rd_q) begin
                     ss_n_q  <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= ST_GAP;
                  end else if (RD_WAIT != 0) begin
                     state_q <= ST_WAIT_RD;
                  end else begin
                     state_q <= ST_SHIFT_IN;
                  end
               end else begin
                  mosi_q     <= tx_shift_q[CMD_W-1];
                  tx_shift_q <= {tx_shift_q[CMD_W-2:0], 1'b0};
                  bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
               end
            end
            ST_WAIT_RD: begin
               if (cyc_cnt_q == CW'(RD_WAIT - 1)) begin
                  bit_cnt_q <= '0;
                  state_q   <= ST_SHIFT_IN;
               end else begin
                  cyc_cnt_q <= cyc_cnt_q + CW'(1);
               end
            end
            ST_SHIFT_IN: begin
               rx_shift_q <= rx_shift_d;
               if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                  rd_data_q  <= rx_shift_d;
                  rd_valid_q <= 1'b1;
                  done_q     <= 1'b1;
                  ss_n_q     <= 1'b1;
                  cyc_cnt_q  <= '0;
                  state_q    <= ST_GAP;
               end else begin
                  bit_cnt_q <= bit_cnt_q + BIT_W'(1);
               end
            end
            ST_GAP: begin
               if (cyc_cnt_q == CW'(GAP_CYCLES - 1)) begin
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cyc_cnt_q <= cyc_cnt_q + CW'(1);
               end
            end
            default: begin
               ready_q <= 1'b1;
               ss_n_q  <= 1'b1;
               mosi_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready    = ready_q;
   assign SS_n     = ss_n_q;
   assign MOSI     = mosi_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign done     = done_q;

endmodule
